// File: rtl/mem_acc_arbiter_if.sv
// Signal bundle between mem_acc_arbiter and its DMA, load/store and SRAM neighbours.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_acc_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 24
);
  logic              dma__memc__write_valid;
  logic [ADDR_W-1:0] dma__memc__write_address;
  logic [DATA_W-1:0] dma__memc__write_data;
  logic              memc__dma__write_ready;
  logic              dma__memc__read_valid;
  logic [ADDR_W-1:0] dma__memc__read_address;
  logic              dma__memc__read_pause;
  logic              memc__dma__read_ready;
  logic [DATA_W-1:0] memc__dma__read_data;
  logic              memc__dma__read_data_valid;

  logic              ldst__memc__request;
  logic              ldst__memc__released;
  logic              ldst__memc__write_valid;
  logic [ADDR_W-1:0] ldst__memc__write_address;
  logic [DATA_W-1:0] ldst__memc__write_data;
  logic              ldst__memc__read_valid;
  logic [ADDR_W-1:0] ldst__memc__read_address;
  logic              memc__ldst__granted;
  logic [DATA_W-1:0] memc__ldst__read_data;
  logic              memc__ldst__read_data_valid;

  logic              memc__sram__cs;
  logic              memc__sram__we;
  logic [ADDR_W-1:0] memc__sram__addr;
  logic [DATA_W-1:0] memc__sram__wdata;
  logic [DATA_W-1:0] sram__memc__rdata;

  modport slave (
    input  dma__memc__write_valid, dma__memc__write_address, dma__memc__write_data,
    input  dma__memc__read_valid, dma__memc__read_address, dma__memc__read_pause,
    output memc__dma__write_ready, memc__dma__read_ready,
    output memc__dma__read_data, memc__dma__read_data_valid,
    input  ldst__memc__request, ldst__memc__released,
    input  ldst__memc__write_valid, ldst__memc__write_address, ldst__memc__write_data,
    input  ldst__memc__read_valid, ldst__memc__read_address,
    output memc__ldst__granted, memc__ldst__read_data, memc__ldst__read_data_valid,
    output memc__sram__cs, memc__sram__we, memc__sram__addr, memc__sram__wdata,
    input  sram__memc__rdata
  );

  modport master (
    output dma__memc__write_valid, dma__memc__write_address, dma__memc__write_data,
    output dma__memc__read_valid, dma__memc__read_address, dma__memc__read_pause,
    input  memc__dma__write_ready, memc__dma__read_ready,
    input  memc__dma__read_data, memc__dma__read_data_valid,
    output ldst__memc__request, ldst__memc__released,
    output ldst__memc__write_valid, ldst__memc__write_address, ldst__memc__write_data,
    output ldst__memc__read_valid, ldst__memc__read_address,
    input  memc__ldst__granted, memc__ldst__read_data, memc__ldst__read_data_valid,
    input  memc__sram__cs, memc__sram__we, memc__sram__addr, memc__sram__wdata,
    output sram__memc__rdata
  );
endinterface

// File: rtl/mem_acc_arbiter.sv
// Lane SRAM front end: posted DMA write buffer with read hazard check, two-stage
// read return pipeline, and an exclusive load/store lock (DMA -> DRAIN -> LDST).
module mem_acc_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 24,
  parameter int WBUF_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_poweron,
  mem_acc_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_DMA, ST_DRAIN, ST_LDST} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wb_addr_q [WBUF_DEPTH];
  logic [ADDR_W-1:0] wb_addr_d [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data_q [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data_d [WBUF_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              dma_rd_p1_q, dma_rd_p1_d, ldst_rd_p1_q, ldst_rd_p1_d;
  logic              dma_rd_vld_q, dma_rd_vld_d, ldst_rd_vld_q, ldst_rd_vld_d;
  logic [DATA_W-1:0] dma_rd_data_q, dma_rd_data_d, ldst_rd_data_q, ldst_rd_data_d;
  logic              granted_q, granted_d;

  logic              hit, full, in_dma, in_ldst;
  logic              wr_ready, rd_ready, wr_acc, rd_acc, drain, ldst_wr, ldst_rd;
  logic [PTR_W-1:0]  offs;
  logic              sram_cs, sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;

  // An entry is live when its distance from head (mod depth) is below count.
  always_comb begin
    hit  = 1'b0;
    offs = '0;
    for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
      offs = PTR_W'(i) - head_q;
      if (({1'b0, offs} < count_q) && (wb_addr_q[i] == bus.dma__memc__read_address))
        hit = 1'b1;
    end
  end

  // Request-side terms are masked by reset so every output reads 0 while it is held.
  assign full     = (count_q == CNT_W'(WBUF_DEPTH));
  assign in_dma   = reset_poweron && (state_q == ST_DMA);
  assign in_ldst  = reset_poweron && (state_q == ST_LDST);
  assign wr_ready = in_dma && !full;
  assign rd_ready = in_dma && !bus.dma__memc__read_pause && !full && !hit;
  assign wr_acc   = bus.dma__memc__write_valid && wr_ready;
  assign rd_acc   = bus.dma__memc__read_valid && rd_ready;
  assign drain    = reset_poweron && (state_q != ST_LDST) && (count_q != '0) && !rd_acc;
  assign ldst_wr  = in_ldst && bus.ldst__memc__write_valid;
  assign ldst_rd  = in_ldst && bus.ldst__memc__read_valid && !bus.ldst__memc__write_valid;

  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (rd_acc) begin
      sram_cs   = 1'b1;
      sram_addr = bus.dma__memc__read_address;
    end else if (drain) begin
      sram_cs    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = wb_addr_q[head_q];
      sram_wdata = wb_data_q[head_q];
    end else if (ldst_wr) begin
      sram_cs    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = bus.ldst__memc__write_address;
      sram_wdata = bus.ldst__memc__write_data;
    end else if (ldst_rd) begin
      sram_cs   = 1'b1;
      sram_addr = bus.ldst__memc__read_address;
    end
  end

  always_comb begin
    state_d   = state_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    case (state_q)
      ST_DMA:   if (bus.ldst__memc__request) state_d = ST_DRAIN;
      ST_DRAIN: if ((count_q == '0) && !dma_rd_p1_q) state_d = ST_LDST;
      ST_LDST:  if (bus.ldst__memc__released) state_d = ST_DMA;
      default:  state_d = ST_DMA;
    endcase

    if (wr_acc) begin
      wb_addr_d[tail_q] = bus.dma__memc__write_address;
      wb_data_d[tail_q] = bus.dma__memc__write_data;
      tail_d            = tail_q + PTR_W'(1);
    end
    if (drain) head_d = head_q + PTR_W'(1);
    case ({wr_acc, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    dma_rd_p1_d    = rd_acc;
    ldst_rd_p1_d   = ldst_rd;
    dma_rd_vld_d   = dma_rd_p1_q;
    ldst_rd_vld_d  = ldst_rd_p1_q;
    dma_rd_data_d  = dma_rd_p1_q  ? bus.sram__memc__rdata : dma_rd_data_q;
    ldst_rd_data_d = ldst_rd_p1_q ? bus.sram__memc__rdata : ldst_rd_data_q;
    granted_d      = (state_d == ST_LDST);
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_q        <= ST_DMA;
      for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
        wb_addr_q[i] <= '0;
        wb_data_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      dma_rd_p1_q    <= 1'b0;
      ldst_rd_p1_q   <= 1'b0;
      dma_rd_vld_q   <= 1'b0;
      ldst_rd_vld_q  <= 1'b0;
      dma_rd_data_q  <= '0;
      ldst_rd_data_q <= '0;
      granted_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wb_addr_q      <= wb_addr_d;
      wb_data_q      <= wb_data_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      dma_rd_p1_q    <= dma_rd_p1_d;
      ldst_rd_p1_q   <= ldst_rd_p1_d;
      dma_rd_vld_q   <= dma_rd_vld_d;
      ldst_rd_vld_q  <= ldst_rd_vld_d;
      dma_rd_data_q  <= dma_rd_data_d;
      ldst_rd_data_q <= ldst_rd_data_d;
      granted_q      <= granted_d;
    end
  end

  assign bus.memc__dma__write_ready      = wr_ready;
  assign bus.memc__dma__read_ready       = rd_ready;
  assign bus.memc__dma__read_data        = dma_rd_data_q;
  assign bus.memc__dma__read_data_valid  = dma_rd_vld_q;
  assign bus.memc__ldst__granted         = granted_q;
  assign bus.memc__ldst__read_data       = ldst_rd_data_q;
  assign bus.memc__ldst__read_data_valid = ldst_rd_vld_q;
  assign bus.memc__sram__cs              = sram_cs;
  assign bus.memc__sram__we              = sram_we;
  assign bus.memc__sram__addr            = sram_addr;
  assign bus.memc__sram__wdata           = sram_wdata;

  // Load/store must not present a read alongside a write; the read would be lost.
  ldst_single_access: assert property (@(posedge clk) disable iff (!reset_poweron)
    (state_q == ST_LDST) |-> !(bus.ldst__memc__write_valid && bus.ldst__memc__read_valid));

endmodule

// File: tb/tb_mem_acc_arbiter.sv
// Bench for mem_acc_arbiter: behavioural SRAM, architectural reference memory with
// read-return scoreboards, a ready/SRAM-port vector table and hand-written sequences.
module tb_mem_acc_arbiter;
  localparam int DW = 32;
  localparam int AW = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_acc_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_acc_arbiter #(.DATA_W(DW), .ADDR_W(AW), .WBUF_DEPTH(4)) dut (
    .clk          (clk),
    .reset_poweron(rst_n),
    .bus          (bus)
  );

  int checks = 0;
  int passes = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endfunction

  function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
    return {8'hA5, a};
  endfunction

  // Behavioural single-port SRAM: read data appears the cycle after cs.
  logic [DW-1:0] sram [logic [AW-1:0]];
  int sram_wr_cnt = 0;
  int sram_rd_cnt = 0;
  always @(posedge clk) begin
    if (bus.memc__sram__cs) begin
      if (bus.memc__sram__we) begin
        sram[bus.memc__sram__addr] = bus.memc__sram__wdata;
        sram_wr_cnt++;
      end else begin
        bus.sram__memc__rdata <= sram.exists(bus.memc__sram__addr) ?
                                 sram[bus.memc__sram__addr] : init_val(bus.memc__sram__addr);
        sram_rd_cnt++;
      end
    end
  end

  // Reference memory holds architectural state: a write is visible once accepted,
  // and a read accepted in the same cycle as a write sees the older value.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t dma_q[$];
  exp_t ldst_q[$];
  exp_t e;
  int cyc = 0;
  int dma_ret = 0;
  logic [DW-1:0] last_dma = '0;
  logic [DW-1:0] last_ldst = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      dma_q.delete();
      ldst_q.delete();
    end else begin
      if (bus.memc__dma__read_data_valid) begin
        chk("dma_return_expected", 128'(dma_q.size() > 0), 128'(1));
        if (dma_q.size() > 0) begin
          e = dma_q.pop_front();
          chk("dma_rdata", 128'(bus.memc__dma__read_data), 128'(e.data));
          chk("dma_latency", 128'(cyc - e.cyc), 128'(2));
        end
        last_dma = bus.memc__dma__read_data;
        dma_ret++;
      end
      if (bus.memc__ldst__read_data_valid) begin
        chk("ldst_return_expected", 128'(ldst_q.size() > 0), 128'(1));
        if (ldst_q.size() > 0) begin
          e = ldst_q.pop_front();
          chk("ldst_rdata", 128'(bus.memc__ldst__read_data), 128'(e.data));
          chk("ldst_latency", 128'(cyc - e.cyc), 128'(2));
        end
        last_ldst = bus.memc__ldst__read_data;
      end
      if (bus.dma__memc__read_valid && bus.memc__dma__read_ready)
        dma_q.push_back('{ref_rd(bus.dma__memc__read_address), cyc});
      if (bus.dma__memc__write_valid && bus.memc__dma__write_ready)
        ref_mem[bus.dma__memc__write_address] = bus.dma__memc__write_data;
      if (bus.memc__ldst__granted) begin
        if (bus.ldst__memc__write_valid)
          ref_mem[bus.ldst__memc__write_address] = bus.ldst__memc__write_data;
        else if (bus.ldst__memc__read_valid)
          ldst_q.push_back('{ref_rd(bus.ldst__memc__read_address), cyc});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_dma(logic wv, logic [AW-1:0] wa, logic [DW-1:0] wd,
                           logic rv, logic [AW-1:0] ra);
    bus.dma__memc__write_valid   = wv;
    bus.dma__memc__write_address = wa;
    bus.dma__memc__write_data    = wd;
    bus.dma__memc__read_valid    = rv;
    bus.dma__memc__read_address  = ra;
  endtask

  task automatic idle();
    drive_dma(1'b0, '0, '0, 1'b0, '0);
    bus.dma__memc__read_pause    = 1'b0;
    bus.ldst__memc__request      = 1'b0;
    bus.ldst__memc__released     = 1'b0;
    bus.ldst__memc__write_valid  = 1'b0;
    bus.ldst__memc__write_address = '0;
    bus.ldst__memc__write_data   = '0;
    bus.ldst__memc__read_valid   = 1'b0;
    bus.ldst__memc__read_address = '0;
  endtask

  function automatic logic [127:0] outs();
    return 128'({bus.memc__dma__write_ready, bus.memc__dma__read_ready,
                 bus.memc__dma__read_data_valid, bus.memc__dma__read_data,
                 bus.memc__ldst__granted, bus.memc__ldst__read_data_valid,
                 bus.memc__ldst__read_data, bus.memc__sram__cs, bus.memc__sram__we,
                 bus.memc__sram__addr, bus.memc__sram__wdata});
  endfunction

  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic          rv;
    logic [AW-1:0] ra;
    logic          exp_wr_rdy;
    logic          exp_rd_rdy;
    logic          exp_cs;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
  } vec_t;

  function automatic vec_t mkv(logic wv, logic [AW-1:0] wa, logic rv, logic [AW-1:0] ra,
                               logic ewr, logic erd, logic ecs, logic ewe,
                               logic [AW-1:0] eaddr);
    vec_t v;
    v.wv = wv; v.wa = wa; v.rv = rv; v.ra = ra;
    v.exp_wr_rdy = ewr; v.exp_rd_rdy = erd; v.exp_cs = ecs; v.exp_we = ewe;
    v.exp_addr = eaddr;
    return v;
  endfunction

  vec_t vt[12];
  int n;
  int base_ret, base_rd, base_wr;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill with concurrent reads so nothing drains, hit the full mark, then watch
    // the drain order and the read hazard against still-buffered addresses.
    vt[0]  = mkv(1'b1, 24'h100, 1'b1, 24'h200, 1'b1, 1'b1, 1'b1, 1'b0, 24'h200);
    vt[1]  = mkv(1'b1, 24'h101, 1'b1, 24'h201, 1'b1, 1'b1, 1'b1, 1'b0, 24'h201);
    vt[2]  = mkv(1'b1, 24'h102, 1'b1, 24'h202, 1'b1, 1'b1, 1'b1, 1'b0, 24'h202);
    vt[3]  = mkv(1'b1, 24'h103, 1'b1, 24'h203, 1'b1, 1'b1, 1'b1, 1'b0, 24'h203);
    vt[4]  = mkv(1'b1, 24'h104, 1'b1, 24'h204, 1'b0, 1'b0, 1'b1, 1'b1, 24'h100);
    vt[5]  = mkv(1'b1, 24'h104, 1'b1, 24'h204, 1'b1, 1'b1, 1'b1, 1'b0, 24'h204);
    vt[6]  = mkv(1'b0, 24'h000, 1'b1, 24'h205, 1'b0, 1'b0, 1'b1, 1'b1, 24'h101);
    vt[7]  = mkv(1'b0, 24'h000, 1'b1, 24'h103, 1'b1, 1'b0, 1'b1, 1'b1, 24'h102);
    vt[8]  = mkv(1'b0, 24'h000, 1'b1, 24'h103, 1'b1, 1'b0, 1'b1, 1'b1, 24'h103);
    vt[9]  = mkv(1'b0, 24'h000, 1'b1, 24'h103, 1'b1, 1'b1, 1'b1, 1'b0, 24'h103);
    vt[10] = mkv(1'b0, 24'h000, 1'b0, 24'h000, 1'b1, 1'b1, 1'b1, 1'b1, 24'h104);
    vt[11] = mkv(1'b0, 24'h000, 1'b0, 24'h000, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000);

    idle();
    repeat (2) @(negedge clk);
    chk("por_outputs_zero", outs(), '0);
    rst_n = 1'b1;
    step();
    chk("post_reset_wr_ready", 128'(bus.memc__dma__write_ready), 128'(1));
    chk("post_reset_rd_ready", 128'(bus.memc__dma__read_ready), 128'(1));

    for (int i = 0; i < 12; i++) begin
      drive_dma(vt[i].wv, vt[i].wa, {8'h5A, vt[i].wa}, vt[i].rv, vt[i].ra);
      @(negedge clk);
      chk($sformatf("v%0d_wr_ready", i), 128'(bus.memc__dma__write_ready), 128'(vt[i].exp_wr_rdy));
      chk($sformatf("v%0d_rd_ready", i), 128'(bus.memc__dma__read_ready), 128'(vt[i].exp_rd_rdy));
      chk($sformatf("v%0d_sram_cs", i), 128'(bus.memc__sram__cs), 128'(vt[i].exp_cs));
      chk($sformatf("v%0d_sram_we", i), 128'(bus.memc__sram__we), 128'(vt[i].exp_we));
      chk($sformatf("v%0d_sram_addr", i), 128'(bus.memc__sram__addr), 128'(vt[i].exp_addr));
      step();
    end
    idle();
    repeat (3) step();

    // Posted write then immediate read of the same word.
    drive_dma(1'b1, 24'h10, 32'hDEADBEEF, 1'b0, '0);
    @(negedge clk);
    chk("wb_write_ready", 128'(bus.memc__dma__write_ready), 128'(1));
    step();
    drive_dma(1'b0, '0, '0, 1'b1, 24'h10);
    @(negedge clk);
    chk("wb_hit_blocks_read", 128'(bus.memc__dma__read_ready), 128'(0));
    step();
    @(negedge clk);
    chk("wb_read_after_drain", 128'(bus.memc__dma__read_ready), 128'(1));
    step();
    idle();
    repeat (3) step();
    chk("wb_readback", 128'(last_dma), 128'(32'hDEADBEEF));

    // Same-cycle read and write to one address: read is older.
    drive_dma(1'b1, 24'h20, 32'h1111, 1'b0, '0);
    step();
    idle();
    repeat (3) step();
    drive_dma(1'b1, 24'h20, 32'h2222, 1'b1, 24'h20);
    @(negedge clk);
    chk("rw_same_wr_ready", 128'(bus.memc__dma__write_ready), 128'(1));
    chk("rw_same_rd_ready", 128'(bus.memc__dma__read_ready), 128'(1));
    step();
    idle();
    repeat (4) step();
    chk("rw_same_old_data", 128'(last_dma), 128'(32'h1111));
    drive_dma(1'b0, '0, '0, 1'b1, 24'h20);
    step();
    idle();
    repeat (4) step();
    chk("rw_later_new_data", 128'(last_dma), 128'(32'h2222));

    // Pause after two accepted reads: exactly two returns, no further issues.
    base_ret = dma_ret;
    base_rd  = sram_rd_cnt;
    drive_dma(1'b0, '0, '0, 1'b1, 24'h400);
    @(negedge clk);
    chk("pause_rd0_ready", 128'(bus.memc__dma__read_ready), 128'(1));
    step();
    drive_dma(1'b0, '0, '0, 1'b1, 24'h401);
    @(negedge clk);
    chk("pause_rd1_ready", 128'(bus.memc__dma__read_ready), 128'(1));
    step();
    drive_dma(1'b0, '0, '0, 1'b1, 24'h402);
    bus.dma__memc__read_pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("pause_ready_low%0d", i), 128'(bus.memc__dma__read_ready), 128'(0));
      step();
    end
    chk("pause_returns", 128'(dma_ret - base_ret), 128'(2));
    chk("pause_sram_reads", 128'(sram_rd_cnt - base_rd), 128'(2));
    bus.dma__memc__read_pause = 1'b0;
    step();
    drive_dma(1'b0, '0, '0, 1'b1, 24'h403);
    step();
    idle();
    repeat (4) step();
    chk("pause_all_returned", 128'(dma_ret - base_ret), 128'(4));

    // Lock handover with two writes still buffered.
    drive_dma(1'b1, 24'h500, 32'h0000_0500, 1'b1, 24'h600);
    step();
    drive_dma(1'b1, 24'h501, 32'h0000_0501, 1'b1, 24'h601);
    step();
    idle();
    bus.ldst__memc__request = 1'b1;
    base_wr = sram_wr_cnt;
    step();
    bus.ldst__memc__request = 1'b0;
    drive_dma(1'b1, 24'h700, 32'h0000_0700, 1'b1, 24'h602);
    @(negedge clk);
    chk("drain_wr_ready_low", 128'(bus.memc__dma__write_ready), 128'(0));
    chk("drain_rd_ready_low", 128'(bus.memc__dma__read_ready), 128'(0));
    step();
    idle();
    n = 0;
    while (!bus.memc__ldst__granted && n < 10) begin
      step();
      n++;
    end
    chk("lock_granted", 128'(bus.memc__ldst__granted), 128'(1));
    chk("lock_drained_writes", 128'(sram_wr_cnt - base_wr), 128'(2));
    chk("lock_dma_wr_blocked", 128'(bus.memc__dma__write_ready), 128'(0));
    chk("lock_dma_rd_blocked", 128'(bus.memc__dma__read_ready), 128'(0));
    bus.ldst__memc__write_valid   = 1'b1;
    bus.ldst__memc__write_address = 24'h40;
    bus.ldst__memc__write_data    = 32'hCAFE0040;
    step();
    bus.ldst__memc__write_valid   = 1'b0;
    bus.ldst__memc__read_valid    = 1'b1;
    bus.ldst__memc__read_address  = 24'h501;
    step();
    bus.ldst__memc__read_address  = 24'h40;
    step();
    bus.ldst__memc__read_valid    = 1'b0;
    repeat (3) step();
    chk("ldst_readback", 128'(last_ldst), 128'(32'hCAFE0040));
    bus.ldst__memc__released = 1'b1;
    @(negedge clk);
    chk("release_cycle_granted", 128'(bus.memc__ldst__granted), 128'(1));
    step();
    bus.ldst__memc__released = 1'b0;
    @(negedge clk);
    chk("release_granted_fall", 128'(bus.memc__ldst__granted), 128'(0));
    chk("release_dma_ready", 128'(bus.memc__dma__write_ready), 128'(1));
    step();
    drive_dma(1'b0, '0, '0, 1'b1, 24'h40);
    step();
    idle();
    repeat (3) step();
    chk("dma_after_lock", 128'(last_dma), 128'(32'hCAFE0040));

    // Reset asserted in the middle of a write burst.
    drive_dma(1'b1, 24'h300, 32'h0000_0300, 1'b0, '0);
    step();
    drive_dma(1'b1, 24'h301, 32'h0000_0301, 1'b0, '0);
    step();
    drive_dma(1'b1, 24'h302, 32'h0000_0302, 1'b0, '0);
    #2;
    rst_n   = 1'b0;
    base_wr = sram_wr_cnt;
    @(negedge clk);
    chk("reset_outputs_zero", outs(), '0);
    idle();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    chk("reset_no_late_write", 128'(sram_wr_cnt - base_wr), 128'(0));
    chk("reset_wr_ready_back", 128'(bus.memc__dma__write_ready), 128'(1));

    repeat (5) step();
    chk("dma_scoreboard_empty", 128'(dma_q.size()), 128'(0));
    chk("ldst_scoreboard_empty", 128'(ldst_q.size()), 128'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mem_acc_arbiter.md
# mem_acc_arbiter

Per-lane memory access front end that consumes the streaming DMA memory interface (`dma__memc__*` / `memc__dma__*`) and the SIMD load/store interface (`ldst__memc__*`), and multiplexes both onto a single-ported lane SRAM. DMA writes are posted into a small write buffer, DMA reads are hazard-checked against that buffer, and the load/store unit takes exclusive ownership of the SRAM through a request/grant/release lock.

## Interface
- `DATA_W`, 32, data width of all read/write paths.
- `ADDR_W`, 24, word address width.
- `WBUF_DEPTH`, 4, DMA write-buffer entries; power of 2, ≥2.

- `clk`  in  1  system clock.
- `reset_poweron`  in  1  asynchronous, active-low reset.
- `dma__memc__write_valid`, `dma__memc__write_address`, `dma__memc__write_data`  in  1/ADDR_W/DATA_W  DMA write request.
- `memc__dma__write_ready`  out  1  write accepted when valid&ready.
- `dma__memc__read_valid`, `dma__memc__read_address`  in  1/ADDR_W  DMA read request.
- `dma__memc__read_pause`  in  1  DMA stops accepting new read issues.
- `memc__dma__read_ready`  out  1  read accepted when valid&ready.
- `memc__dma__read_data`, `memc__dma__read_data_valid`  out  DATA_W/1  DMA read return.
- `ldst__memc__request`, `ldst__memc__released`  in  1  lock request / release pulse.
- `ldst__memc__write_valid`, `ldst__memc__write_address`, `ldst__memc__write_data`  in  1/ADDR_W/DATA_W.
- `ldst__memc__read_valid`, `ldst__memc__read_address`  in  1/ADDR_W.
- `memc__ldst__granted`  out  1  lock held by load/store.
- `memc__ldst__read_data`, `memc__ldst__read_data_valid`  out  DATA_W/1.
- `memc__sram__cs`, `memc__sram__we`, `memc__sram__addr`, `memc__sram__wdata`  out  1/1/ADDR_W/DATA_W  SRAM port, one access per cycle.
- `sram__memc__rdata`  in  DATA_W  valid the cycle after a read `cs`.

## Operation
- FSM states: `DMA` (reset), `DRAIN`, `LDST`.
- `DMA`: per cycle, at most one SRAM access. Accepted DMA read issues to SRAM that cycle; otherwise, if write buffer non-empty, head entry drains (`cs=1,we=1`).
- `write_ready = (state==DMA) && (count != WBUF_DEPTH)`; no push-through-pop when full.
- `read_ready = (state==DMA) && !read_pause && (count != WBUF_DEPTH) && !hit`, where `hit` = read address equals the address of any valid buffer entry. Full buffer forces drain priority (no read starvation of writes).
- Same-cycle DMA read and write to the same address: read is older, returns pre-write data.
- Writes drain in FIFO order; buffer count width clog2(WBUF_DEPTH)+1.
- `ldst__memc__request` high in `DMA` -> `DRAIN` next cycle: both DMA readys low; buffer drains one per cycle; wait until count==0 and no DMA read in flight -> `LDST`.
- `LDST`: `granted=1`; ldst write (priority) or read passes directly to SRAM. `ldst__memc__released` pulse -> `DMA` next cycle. `request` ignored outside `DMA`; `released` ignored outside `LDST`. Write+read valid same cycle in `LDST`: write issues, read is dropped (ldst protocol violation, flagged by assertion).
- In-flight reads always complete, even under `read_pause` (DMA must absorb up to 2 returns after pausing).

## Timing
- Reset (async assert, sync deassert by caller): all outputs 0, FSM `DMA`, buffer empty, read pipeline cleared; in-flight data discarded.
- Read latency: accept/issue cycle T, SRAM data T+1, registered `*_read_data_valid`/`*_read_data` at T+2. Full throughput: one read per cycle.
- Write: accepted at T, earliest SRAM write at T+1.
- `granted` rises the cycle after entering `LDST`-condition (registered), falls the cycle after `released`.
- `read_ready`/`write_ready` are combinational from registered state and current request address/pause.

## Test plan
- Reset: drive 3 writes, assert reset mid-stream -> all outputs 0, count 0, no SRAM write after reset edge.
- Write/readback: write 0xDEADBEEF to 0x000010, read 0x000010 next cycle -> read_ready low (hit) until drained, then data 0xDEADBEEF at T+2.
- Full buffer: 4 back-to-back writes with reads held -> write_ready low on 5th, drains 1/cycle, ready returns after first drain.
- Same-cycle R/W to 0x20 (old 0x1111, new 0x2222) -> read returns 0x1111; later read returns 0x2222.
- Pause: 4 back-to-back reads, pause after 2nd accept -> read_ready low, exactly 2 returns complete, no more issues.
- Lock: request with 2 buffered writes -> 2 drain cycles, granted=1; ldst read 0x40 returns at T+2; released -> granted 0 next cycle, DMA resumes.
